mjpeg_pkt_buffer_ctrl: RTL

Parametrised camera-to-MJPEG frame gate and packet buffer writer in the i_cam_pclk domain. It holds the encoder off for a configurable number of start-up frames, selects one frame in every FRAME_SKIP+1, and gates one frame of RGB888 into the encoder. Encoder bytes are packed into WORD_W-bit words in a ring of NUM_BUF packet buffers inside an external dual-port BRAM. Closed packets are handed to the UDP sender with a valid/ready plus release handshake.

---
 rtl/mjpeg_pkt_buffer_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mjpeg_pkt_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// mjpeg_pkt_buffer_ctrl
//
// Purpose
//   Camera-to-MJPEG frame gate and packet buffer writer (i_cam_pclk domain).
//   - Keeps the encoder in reset for STARTUP_FRAMES vsync rises.
//   - Picks one frame in every FRAME_SKIP+1 and gates its pixels into the
//     encoder.
//   - Packs encoded bytes big-endian into WORD_W-bit words. The words go to
//     a ring of NUM_BUF packet buffers of PKT_WORDS words each, held in an
//     external BRAM.
//   - Hands each closed packet to the sender with valid/ready. A separate
//     release pulse returns the buffer to the ring.
//
// Ports
//   i_cam_pclk, rst_n           clock, async active-low reset
//   i_cam_vsync/de/rgb888_pclk  camera timing; i_cam_data_rgb888 pixel data
//   o_mjpeg_rst/de/data         encoder run enable, pixel strobe, pixel data
//   i_mjpeg_de/data/down        encoded byte stream and end-of-frame pulse
//   o_buf_wr_en/addr/wr_data    BRAM port-A write ({buffer, word} address)
//   o_pkt_* / i_pkt_ready       packet descriptor, valid/ready handshake
//   i_pkt_release               frees the oldest accepted buffer
//   o_busy, o_overflow          status: FSM not idle, sticky truncation flag
//   o_frames_dropped            drop statistics (zero unless enabled)
//
// Build option
//   MJPEG_DROP_STATS_EN  when defined, o_frames_dropped is a saturating count
//                        of DROP entries plus selected frames that were
//                        skipped because the FSM was busy.
//
// PKT_WORDS must be at least 2, so that the word index has a nonzero width.
// ---------------------------------------------------------------------------
module mjpeg_pkt_buffer_ctrl #(
    parameter int  STARTUP_FRAMES = 30,
    parameter int  WORD_W         = 128,
    parameter int  NUM_BUF        = 4,
    parameter int  PKT_WORDS      = 64,
    parameter int  FRAME_SKIP     = 0,
    localparam int BUF_W          = $clog2(NUM_BUF),
    localparam int ADDR_W         = $clog2(NUM_BUF*PKT_WORDS)
) (
    input  logic              i_cam_pclk,
    input  logic              rst_n,
    input  logic              i_cam_vsync,
    input  logic              i_cam_de,
    input  logic              i_cam_rgb888_pclk,
    input  logic [23:0]       i_cam_data_rgb888,
    output logic              o_mjpeg_rst,
    output logic              o_mjpeg_de,
    output logic [23:0]       o_mjpeg_data,
    input  logic              i_mjpeg_de,
    input  logic [7:0]        i_mjpeg_data,
    input  logic              i_mjpeg_down,
    output logic              o_buf_wr_en,
    output logic [ADDR_W-1:0] o_buf_addr,
    output logic [WORD_W-1:0] o_buf_wr_data,
    output logic              o_pkt_valid,
    input  logic              i_pkt_ready,
    output logic [BUF_W-1:0]  o_pkt_buf,
    output logic [15:0]       o_pkt_bytes,
    output logic              o_pkt_last,
    output logic [7:0]        o_pkt_seq,
    output logic [14:0]       o_pkt_frame_rank,
    input  logic              i_pkt_release,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [15:0]       o_frames_dropped
);

    localparam int          BPW       = WORD_W / 8;
    localparam int          BI_W      = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int          WI_W      = $clog2(PKT_WORDS);
    localparam int          CNT_W     = BUF_W + 1;
    localparam logic [15:0] PKT_BYTES = 16'(PKT_WORDS * BPW);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        ENCODE = 3'd2,
        FLUSH  = 3'd3,
        DROP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [BUF_W-1:0] buf_idx;
        logic [15:0]      bytes;
        logic             last;
        logic [7:0]       seq;
        logic [14:0]      rank;
    } desc_t;

    state_t state, state_nxt;

    // Edge detection and frame selection
    logic       vsync_q, de_q, vs_rise, de_rise;
    logic [5:0] startup_cnt;
    logic       run_en;
    logic [7:0] skip_cnt;
    logic       sel_frame;

    // Encoder control
    logic mjpeg_run, gate;

    // Packing state for the buffer currently being filled
    logic [WORD_W-1:0] acc, acc_ins;
    logic [BI_W-1:0]   bidx;
    logic [WI_W-1:0]   widx;
    logic              filling;
    logic [BUF_W-1:0]  wr_buf;
    logic [7:0]        seq;
    logic [14:0]       rank;
    logic              word_full, pkt_full;
    logic [15:0]       cur_bytes;

    // FSM strobes
    logic byte_ok, drop_now, flush_now, frame_done, arm_run;

    // Datapath strobes
    logic              word_wr, close_pkt, close_last;
    logic [WORD_W-1:0] word_data;
    logic [15:0]       close_bytes;

    // Write port registers
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [WORD_W-1:0] wr_data_r;

    // A closed packet waits one cycle in pend before it enters the queue.
    // The descriptor therefore appears the cycle after its last word write.
    logic  pend;
    desc_t pend_desc;

    // Descriptor queue and buffer accounting
    desc_t            fifo [NUM_BUF];
    logic [BUF_W-1:0] rd_ptr, wq_ptr;
    logic [CNT_W-1:0] q_cnt, held, free_cnt;
    logic             pop, held_dec;
    logic             overflow_r;

    assign vs_rise   = i_cam_vsync & ~vsync_q;
    assign de_rise   = i_cam_de & ~de_q;
    assign run_en    = (startup_cnt == 6'(STARTUP_FRAMES));
    assign sel_frame = vs_rise & run_en & (skip_cnt == 8'd0);

    assign word_full = (bidx == BI_W'(BPW - 1));
    assign pkt_full  = (widx == WI_W'(PKT_WORDS - 1));
    assign cur_bytes = 16'(widx) * 16'(BPW) + 16'(bidx);

    // The pending descriptor and the open packet each hold a buffer
    // until they reach the queue.
    assign free_cnt = CNT_W'(NUM_BUF) - CNT_W'(filling) - CNT_W'(pend) - q_cnt - held;

    assign pop      = o_pkt_valid & i_pkt_ready;
    assign held_dec = i_pkt_release & (held != '0);

    // Insert the incoming byte at its big-endian slot.
    assign acc_ins = acc | (WORD_W'(i_mjpeg_data) << (8 * (BPW - 1 - int'(bidx))));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        byte_ok    = 1'b0;
        drop_now   = 1'b0;
        flush_now  = 1'b0;
        frame_done = 1'b0;
        arm_run    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_frame) state_nxt = ARMED;
            end
            ARMED: begin
                if (de_rise) begin
                    state_nxt = ENCODE;
                    arm_run   = 1'b1;
                end
            end
            ENCODE: begin
                if (i_mjpeg_de) begin
                    // A new packet is opened only when a byte arrives, so
                    // the ring check happens at the first byte.
                    if (!filling && free_cnt == '0) drop_now = 1'b1;
                    else                            byte_ok  = 1'b1;
                end
                if (drop_now) begin
                    state_nxt  = i_mjpeg_down ? IDLE : DROP;
                    frame_done = i_mjpeg_down;
                end else if (i_mjpeg_down) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                flush_now  = 1'b1;
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            DROP: begin
                if (i_mjpeg_down) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------- word / close select
    always_comb begin
        word_wr     = 1'b0;
        word_data   = acc_ins;
        close_pkt   = 1'b0;
        close_bytes = PKT_BYTES;
        close_last  = 1'b0;
        if (byte_ok && word_full) begin
            word_wr   = 1'b1;
            close_pkt = pkt_full;
        end
        if (flush_now) begin
            // Partial word is already zero-padded because acc is cleared
            // after every write. An empty packet still needs a buffer for
            // its zero-length descriptor.
            word_wr     = (bidx != '0);
            word_data   = acc;
            close_bytes = cur_bytes;
            close_last  = 1'b1;
            close_pkt   = filling | (free_cnt != '0);
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            startup_cnt <= '0;
            skip_cnt    <= '0;
            mjpeg_run   <= 1'b0;
            gate        <= 1'b0;
            acc         <= '0;
            bidx        <= '0;
            widx        <= '0;
            filling     <= 1'b0;
            wr_buf      <= '0;
            seq         <= '0;
            rank        <= '0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            pend        <= 1'b0;
            pend_desc   <= '0;
            overflow_r  <= 1'b0;
        end else begin
            vsync_q <= i_cam_vsync;
            de_q    <= i_cam_de;
            wr_en_r <= 1'b0;
            pend    <= 1'b0;

            if (vs_rise && !run_en) startup_cnt <= startup_cnt + 6'd1;
            if (vs_rise && run_en)
                skip_cnt <= (skip_cnt == 8'(FRAME_SKIP)) ? 8'd0 : skip_cnt + 8'd1;

            if (arm_run) begin
                mjpeg_run <= 1'b1;
                gate      <= 1'b1;
            end else begin
                if (vs_rise || frame_done) gate      <= 1'b0;
                if (frame_done)            mjpeg_run <= 1'b0;
            end

            if (word_wr) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= {wr_buf, widx};
                wr_data_r <= word_data;
            end

            if (close_pkt) begin
                pend      <= 1'b1;
                pend_desc <= '{buf_idx: wr_buf, bytes: close_bytes, last: close_last,
                               seq: seq, rank: rank};
                wr_buf    <= wr_buf + 1'b1;
                seq       <= seq + 8'd1;
            end

            if (frame_done) begin
                acc     <= '0;
                bidx    <= '0;
                widx    <= '0;
                filling <= 1'b0;
            end else if (byte_ok) begin
                filling <= ~(word_full & pkt_full);
                if (word_full) begin
                    acc  <= '0;
                    bidx <= '0;
                    widx <= pkt_full ? '0 : widx + 1'b1;
                end else begin
                    acc  <= acc_ins;
                    bidx <= bidx + 1'b1;
                end
            end

            // seq restarts per frame; this overrides the increment above.
            if (frame_done) begin
                rank <= rank + 15'd1;
                seq  <= '0;
            end

            if (drop_now || (flush_now && !close_pkt)) overflow_r <= 1'b1;
        end
    end

    // ------------------------------------------------- descriptor queue
    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUF; i++) fifo[i] <= '0;
            rd_ptr <= '0;
            wq_ptr <= '0;
            q_cnt  <= '0;
            held   <= '0;
        end else begin
            if (pend) begin
                fifo[wq_ptr] <= pend_desc;
                wq_ptr       <= wq_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            q_cnt <= q_cnt + CNT_W'(pend) - CNT_W'(pop);
            held  <= held + CNT_W'(pop) - CNT_W'(held_dec);
        end
    end

`ifdef MJPEG_DROP_STATS_EN
    logic [1:0]  drop_inc;
    logic [15:0] drop_cnt;

    assign drop_inc = {1'b0, drop_now} + {1'b0, sel_frame && (state != IDLE)};

    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop_cnt > 16'hFFFF - 16'(drop_inc))
            drop_cnt <= 16'hFFFF;
        else
            drop_cnt <= drop_cnt + 16'(drop_inc);
    end

    assign o_frames_dropped = drop_cnt;
`else
    assign o_frames_dropped = '0;
`endif

    // ------------------------------------------------------------ outputs
    assign o_mjpeg_rst      = mjpeg_run;
    assign o_mjpeg_de       = i_cam_rgb888_pclk & i_cam_de & gate;
    assign o_mjpeg_data     = i_cam_data_rgb888;
    assign o_buf_wr_en      = wr_en_r;
    assign o_buf_addr       = wr_addr_r;
    assign o_buf_wr_data    = wr_data_r;
    assign o_pkt_valid      = (q_cnt != '0);
    assign o_pkt_buf        = fifo[rd_ptr].buf_idx;
    assign o_pkt_bytes      = fifo[rd_ptr].bytes;
    assign o_pkt_last       = fifo[rd_ptr].last;
    assign o_pkt_seq        = fifo[rd_ptr].seq;
    assign o_pkt_frame_rank = fifo[rd_ptr].rank;
    assign o_busy           = (state != IDLE);
    assign o_overflow       = overflow_r;

endmodule
